// File: rtl/vis_sequencer_pkg.sv
// Shared state encoding and defaults for the visibility acquisition sequencer.
package vis_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_DEF = 4096;

endpackage

// File: rtl/vis_seq_timer.sv
// DRAIN watchdog: counts cycles while run is high, flags the last allowed cycle.
module vis_seq_timer #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clock,
    input  logic areset_n,
    input  logic run,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = run && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/vis_sequencer.sv
// Acquisition controller: arm, gate N blocks, drain, report.
// Optional DRAIN watchdog enabled by defining VIS_SEQ_WATCHDOG_EN.
module vis_sequencer
    import vis_sequencer_pkg::*;
#(
    parameter int unsigned NBITS   = 8,
    parameter int unsigned FBITS   = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             areset_n,
    input  logic             cfg_start_i,
    input  logic             cfg_stop_i,
    input  logic             cfg_cont_i,
    input  logic [NBITS-1:0] cfg_blocks_i,
    input  logic             blk_valid_i,
    input  logic             blk_first_i,
    input  logic             blk_last_i,
    input  logic             acc_valid_i,
    input  logic             acc_last_i,
    input  logic             acc_ready_i,
    output logic             vis_enable_o,
    output logic [NBITS-1:0] vis_count_o,
    output logic             vis_start_o,
    output logic             vis_frame_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o,
    output logic             timeout_o,
    output logic [FBITS-1:0] frames_o
);

    state_t           state_q, state_d;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] count_q, count_d;
    logic [FBITS-1:0] frames_q, frames_d;
    logic             stop_q, stop_d;
    logic             enable_q, enable_d;
    logic             start_q, start_d;
    logic             frame_q, frame_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;
    logic             expired;
    logic             active;

    assign active = (state_q == RUN) || (state_q == DRAIN);

`ifdef VIS_SEQ_WATCHDOG_EN
    vis_seq_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock    (clock),
        .areset_n (areset_n),
        .run      (state_q == DRAIN),
        .expired  (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        count_d  = count_q;
        frames_d = frames_q;
        stop_d   = stop_q;
        enable_d = enable_q;
        start_d  = 1'b0;
        frame_d  = frame_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;

        if (active && acc_valid_i && !acc_ready_i) ovf_d = 1'b1;
        if (active && cfg_stop_i) stop_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (cfg_start_i && !cfg_stop_i) begin
                    count_d = (cfg_blocks_i == '0) ? NBITS'(1) : cfg_blocks_i;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (cfg_stop_i) begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                end else if (blk_valid_i && blk_first_i) begin
                    start_d = 1'b1;
                    frame_d = 1'b1;
                    // a 1-beat opening block already counts as one block
                    if (blk_last_i && count_q == NBITS'(1)) begin
                        state_d  = DRAIN;
                        enable_d = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        state_d  = RUN;
                        enable_d = 1'b1;
                        cnt_d    = blk_last_i ? NBITS'(1) : '0;
                    end
                end
            end
            RUN: begin
                if (blk_valid_i && blk_last_i) begin
                    if (cnt_q == count_q - NBITS'(1)) begin
                        state_d  = DRAIN;
                        enable_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + NBITS'(1);
                    end
                end
            end
            DRAIN: begin
                if (acc_valid_i && acc_ready_i && acc_last_i) begin
                    done_d   = 1'b1;
                    frames_d = frames_q + FBITS'(1);
                    frame_d  = 1'b0;
                    if (cfg_cont_i && !stop_q && !cfg_stop_i) begin
                        state_d = ARM;
                    end else begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end
                end else if (expired) begin
                    tmo_d   = 1'b1;
                    frame_d = 1'b0;
                    state_d = IDLE;
                    stop_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            count_q  <= NBITS'(1);
            frames_q <= '0;
            stop_q   <= 1'b0;
            enable_q <= 1'b0;
            start_q  <= 1'b0;
            frame_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            frames_q <= frames_d;
            stop_q   <= stop_d;
            enable_q <= enable_d;
            start_q  <= start_d;
            frame_q  <= frame_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            tmo_q    <= tmo_d;
        end
    end

    assign vis_enable_o = enable_q;
    assign vis_count_o  = count_q;
    assign vis_start_o  = start_q;
    assign vis_frame_o  = frame_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;
    assign timeout_o    = tmo_q;
    assign frames_o     = frames_q;

endmodule

// File: tb/tb_vis_sequencer.sv
// Directed self-checking bench for vis_sequencer.
module tb_vis_sequencer;

    logic        clock = 1'b0;
    logic        areset_n = 1'b0;
    logic        cfg_start_i = 0, cfg_stop_i = 0, cfg_cont_i = 0;
    logic [7:0]  cfg_blocks_i = 0;
    logic        blk_valid_i = 0, blk_first_i = 0, blk_last_i = 0;
    logic        acc_valid_i = 0, acc_last_i = 0, acc_ready_i = 1;
    logic        vis_enable_o, vis_start_o, vis_frame_o;
    logic        busy_o, done_o, overflow_o, timeout_o;
    logic [7:0]  vis_count_o;
    logic [15:0] frames_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    vis_sequencer #(.NBITS(8), .FBITS(16), .TIMEOUT(16)) dut (
        .clock(clock), .areset_n(areset_n),
        .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i),
        .cfg_cont_i(cfg_cont_i), .cfg_blocks_i(cfg_blocks_i),
        .blk_valid_i(blk_valid_i), .blk_first_i(blk_first_i),
        .blk_last_i(blk_last_i), .acc_valid_i(acc_valid_i),
        .acc_last_i(acc_last_i), .acc_ready_i(acc_ready_i),
        .vis_enable_o(vis_enable_o), .vis_count_o(vis_count_o),
        .vis_start_o(vis_start_o), .vis_frame_o(vis_frame_o),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o),
        .timeout_o(timeout_o), .frames_o(frames_o)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input logic v, input logic f, input logic l);
        blk_valid_i = v; blk_first_i = f; blk_last_i = l;
        step();
        blk_valid_i = 0; blk_first_i = 0; blk_last_i = 0;
    endtask

    task automatic acc_end();
        acc_valid_i = 1; acc_ready_i = 1; acc_last_i = 1;
        step();
        acc_valid_i = 0; acc_last_i = 0;
    endtask

    task automatic start(input logic [7:0] nb);
        cfg_blocks_i = nb; cfg_start_i = 1;
        step();
        cfg_start_i = 0;
    endtask

    task automatic test_reset();
        areset_n = 0;
        step(); step();
        n_chk++;
        if ({busy_o, vis_enable_o, vis_start_o, vis_frame_o, done_o, overflow_o, timeout_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0",
                {busy_o, vis_enable_o, vis_start_o, vis_frame_o, done_o, overflow_o, timeout_o});
        end
        n_chk++;
        if (vis_count_o !== 8'd1 || frames_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counts got count=%0d frames=%0d want 1/0", vis_count_o, frames_o);
        end
        areset_n = 1;
        step();
    endtask

    task automatic test_three_blocks();
        start(8'd3);
        n_chk++;
        if (busy_o !== 1 || vis_start_o !== 0 || vis_count_o !== 8'd3) begin
            n_fail++;
            $display("FAIL arm got busy=%b start=%b count=%0d want 1/0/3", busy_o, vis_start_o, vis_count_o);
        end
        beat(1, 1, 0);
        n_chk++;
        if (vis_start_o !== 1 || vis_enable_o !== 1 || vis_frame_o !== 1) begin
            n_fail++;
            $display("FAIL frame_start got s=%b e=%b f=%b want 111", vis_start_o, vis_enable_o, vis_frame_o);
        end
        beat(1, 0, 1);
        n_chk++;
        if (vis_start_o !== 0 || vis_enable_o !== 1) begin
            n_fail++;
            $display("FAIL start_pulse got s=%b e=%b want 0/1", vis_start_o, vis_enable_o);
        end
        beat(1, 1, 0);
        beat(1, 0, 1);
        beat(1, 1, 0);
        n_chk++;
        if (vis_enable_o !== 1) begin
            n_fail++;
            $display("FAIL enable_hold got %b want 1", vis_enable_o);
        end
        beat(1, 0, 1);
        n_chk++;
        if (vis_enable_o !== 0 || vis_frame_o !== 1 || busy_o !== 1) begin
            n_fail++;
            $display("FAIL drain_entry got e=%b f=%b b=%b want 0/1/1", vis_enable_o, vis_frame_o, busy_o);
        end
        acc_end();
        n_chk++;
        if (done_o !== 1 || frames_o !== 16'd1 || busy_o !== 0 || vis_frame_o !== 0) begin
            n_fail++;
            $display("FAIL done1 got d=%b fr=%0d b=%b f=%b want 1/1/0/0", done_o, frames_o, busy_o, vis_frame_o);
        end
        step();
        n_chk++;
        if (done_o !== 0) begin
            n_fail++;
            $display("FAIL done_pulse got %b want 0", done_o);
        end
    endtask

    task automatic test_zero_blocks();
        start(8'd0);
        n_chk++;
        if (vis_count_o !== 8'd1) begin
            n_fail++;
            $display("FAIL zero_count got %0d want 1", vis_count_o);
        end
        beat(1, 1, 0);
        beat(1, 0, 1);
        n_chk++;
        if (vis_enable_o !== 0 || busy_o !== 1) begin
            n_fail++;
            $display("FAIL zero_drain got e=%b b=%b want 0/1", vis_enable_o, busy_o);
        end
        acc_end();
        n_chk++;
        if (frames_o !== 16'd2 || busy_o !== 0) begin
            n_fail++;
            $display("FAIL zero_done got fr=%0d b=%b want 2/0", frames_o, busy_o);
        end
    endtask

    task automatic test_continuous();
        int starts;
        cfg_cont_i = 1;
        start(8'd2);
        beat(1, 1, 0);
        beat(1, 0, 1);
        beat(1, 1, 1);
        n_chk++;
        if (vis_enable_o !== 0) begin
            n_fail++;
            $display("FAIL cont_drain1 got e=%b want 0", vis_enable_o);
        end
        acc_end();
        n_chk++;
        if (done_o !== 1 || frames_o !== 16'd3 || busy_o !== 1) begin
            n_fail++;
            $display("FAIL cont_rearm got d=%b fr=%0d b=%b want 1/3/1", done_o, frames_o, busy_o);
        end
        beat(1, 1, 0);
        n_chk++;
        if (vis_start_o !== 1) begin
            n_fail++;
            $display("FAIL cont_start2 got %b want 1", vis_start_o);
        end
        cfg_stop_i = 1;
        beat(1, 0, 1);
        cfg_stop_i = 0;
        beat(1, 1, 1);
        acc_end();
        n_chk++;
        if (done_o !== 1 || frames_o !== 16'd4 || busy_o !== 0) begin
            n_fail++;
            $display("FAIL cont_stop got d=%b fr=%0d b=%b want 1/4/0", done_o, frames_o, busy_o);
        end
        cfg_cont_i = 0;
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            beat(1, 1, 0);
            if (vis_start_o === 1'b1) starts++;
        end
        n_chk++;
        if (starts !== 0 || busy_o !== 0) begin
            n_fail++;
            $display("FAIL cont_no_third got starts=%0d b=%b want 0/0", starts, busy_o);
        end
    endtask

    task automatic test_start_stop();
        cfg_stop_i = 1;
        start(8'd4);
        cfg_stop_i = 0;
        n_chk++;
        if (busy_o !== 0) begin
            n_fail++;
            $display("FAIL start_stop_idle got b=%b want 0", busy_o);
        end
        start(8'd4);
        cfg_stop_i = 1;
        beat(1, 1, 0);
        cfg_stop_i = 0;
        n_chk++;
        if (busy_o !== 0 || vis_start_o !== 0 || vis_enable_o !== 0) begin
            n_fail++;
            $display("FAIL arm_abort got b=%b s=%b e=%b want 000", busy_o, vis_start_o, vis_enable_o);
        end
        n_chk++;
        if (frames_o !== 16'd4) begin
            n_fail++;
            $display("FAIL abort_frames got %0d want 4", frames_o);
        end
    endtask

    task automatic test_overflow();
        start(8'd1);
        beat(1, 1, 0);
        beat(1, 0, 1);
        acc_valid_i = 1; acc_ready_i = 0;
        step();
        acc_valid_i = 0; acc_ready_i = 1;
        n_chk++;
        if (overflow_o !== 1 || busy_o !== 1) begin
            n_fail++;
            $display("FAIL ovf_set got o=%b b=%b want 1/1", overflow_o, busy_o);
        end
        acc_end();
        n_chk++;
        if (done_o !== 1 || overflow_o !== 1 || frames_o !== 16'd5) begin
            n_fail++;
            $display("FAIL ovf_done got d=%b o=%b fr=%0d want 1/1/5", done_o, overflow_o, frames_o);
        end
        step();
        n_chk++;
        if (overflow_o !== 1) begin
            n_fail++;
            $display("FAIL ovf_sticky got %b want 1", overflow_o);
        end
        start(8'd1);
        n_chk++;
        if (overflow_o !== 0) begin
            n_fail++;
            $display("FAIL ovf_clear got %b want 0", overflow_o);
        end
        cfg_stop_i = 1;
        step();
        cfg_stop_i = 0;
    endtask

    task automatic test_watchdog();
        int early;
        start(8'd1);
        beat(1, 1, 0);
        beat(1, 0, 1);
`ifdef VIS_SEQ_WATCHDOG_EN
        early = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (busy_o !== 1'b1) early++;
        end
        n_chk++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL wd_early got %0d idle cycles want 0", early);
        end
        step();
        n_chk++;
        if (timeout_o !== 1 || busy_o !== 0 || frames_o !== 16'd5 || done_o !== 0) begin
            n_fail++;
            $display("FAIL wd_expire got t=%b b=%b fr=%0d d=%b want 1/0/5/0",
                timeout_o, busy_o, frames_o, done_o);
        end
`else
        early = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy_o !== 1'b1 || timeout_o !== 1'b0) early++;
        end
        n_chk++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL no_wd got %0d bad cycles want 0", early);
        end
        acc_end();
        n_chk++;
        if (frames_o !== 16'd6 || timeout_o !== 0) begin
            n_fail++;
            $display("FAIL no_wd_done got fr=%0d t=%b want 6/0", frames_o, timeout_o);
        end
`endif
    endtask

    task automatic test_async_reset();
        start(8'd3);
        beat(1, 1, 0);
        #2;
        areset_n = 0;
        #1;
        n_chk++;
        if (busy_o !== 0 || vis_enable_o !== 0 || vis_frame_o !== 0 ||
            frames_o !== 16'd0 || vis_count_o !== 8'd1) begin
            n_fail++;
            $display("FAIL async_reset got b=%b e=%b f=%b fr=%0d c=%0d want 0/0/0/0/1",
                busy_o, vis_enable_o, vis_frame_o, frames_o, vis_count_o);
        end
        step();
        areset_n = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_three_blocks();
        test_zero_blocks();
        test_continuous();
        test_start_stop();
        test_overflow();
        test_watchdog();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
